// File: rtl/led_model.sv
// Daisy-chained serial RGB LED model: shifts in 24 bits, forwards the rest.
// Optional sticky short-frame flag via macro LED_MODEL_FRAME_ERR_EN.
module led_model #(
  parameter int FREQ     = 100_000_000,
  parameter int LATCH_US = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        SDI,
  input  logic        CKI,
  output logic        SDO,
  output logic        CKO,
  output logic [23:0] rgb
`ifdef LED_MODEL_FRAME_ERR_EN
  ,
  output logic        frame_err
`endif
);

  localparam int LATCH_CYCLES = FREQ / 1_000_000 * LATCH_US;
  localparam int LW = $clog2(LATCH_CYCLES + 1);
  localparam logic [LW-1:0] LAT_MAX = LW'(LATCH_CYCLES);
  localparam logic [LW-1:0] LAT_PRE = LW'(LATCH_CYCLES - 1);
  localparam logic [4:0] FULL = 5'd24;

  logic          sdi_s1_q, sdi_s1_d;
  logic          sdi_s2_q, sdi_s2_d;
  logic          cki_s1_q, cki_s1_d;
  logic          cki_s2_q, cki_s2_d;
  logic          cki_d1_q, cki_d1_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [23:0]   shift_q, shift_d;
  logic [LW-1:0] low_cnt_q, low_cnt_d;
  logic          fwd_q, fwd_d;
  logic          cko_q, cko_d;
  logic          sdo_q, sdo_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          ferr_q, ferr_d;

  logic rise;
  logic full;
  logic latch;

  // Next-state: sync, edge detect, shifting, low-time latch, forwarding
  always_comb begin
    rise      = cki_s2_q & ~cki_d1_q;
    full      = (bit_cnt_q == FULL);
    latch     = ~cki_s2_q & (low_cnt_q == LAT_PRE);
    sdi_s1_d  = SDI;
    sdi_s2_d  = sdi_s1_q;
    cki_s1_d  = CKI;
    cki_s2_d  = cki_s1_q;
    cki_d1_d  = cki_s2_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    low_cnt_d = low_cnt_q;
    rgb_d     = rgb_q;
    ferr_d    = ferr_q;

    if (cki_s2_q) begin
      low_cnt_d = '0;
    end else if (low_cnt_q != LAT_MAX) begin
      low_cnt_d = low_cnt_q + 1'b1;
    end

    if (latch) begin
      bit_cnt_d = '0;
    end else if (rise && !full) begin
      shift_d   = {shift_q[22:0], sdi_s2_q};
      bit_cnt_d = bit_cnt_q + 5'd1;
    end

    if (latch && full) begin
      rgb_d = shift_q;
    end
    if (latch && !full && bit_cnt_q != 5'd0) begin
      ferr_d = 1'b1;
    end

    // The 24th bit's own high phase is not passed on; forwarding
    // opens on the first low cycle after the register fills.
    fwd_d = (fwd_q | (full & ~cki_s2_q)) & ~latch;
    cko_d = fwd_q & cki_s2_q;
    sdo_d = fwd_q & ~latch & sdi_s2_q;
  end

  // State registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sdi_s1_q  <= 1'b0;
      sdi_s2_q  <= 1'b0;
      cki_s1_q  <= 1'b0;
      cki_s2_q  <= 1'b0;
      cki_d1_q  <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      low_cnt_q <= '0;
      fwd_q     <= 1'b0;
      cko_q     <= 1'b0;
      sdo_q     <= 1'b0;
      rgb_q     <= '0;
      ferr_q    <= 1'b0;
    end else begin
      sdi_s1_q  <= sdi_s1_d;
      sdi_s2_q  <= sdi_s2_d;
      cki_s1_q  <= cki_s1_d;
      cki_s2_q  <= cki_s2_d;
      cki_d1_q  <= cki_d1_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      low_cnt_q <= low_cnt_d;
      fwd_q     <= fwd_d;
      cko_q     <= cko_d;
      sdo_q     <= sdo_d;
      rgb_q     <= rgb_d;
`ifdef LED_MODEL_FRAME_ERR_EN
      ferr_q    <= ferr_d;
`else
      ferr_q    <= 1'b0;
`endif
    end
  end

  assign SDO = sdo_q;
  assign CKO = cko_q;
  assign rgb = rgb_q;
`ifdef LED_MODEL_FRAME_ERR_EN
  assign frame_err = ferr_q;
`else
  logic unused_ferr;
  assign unused_ferr = ferr_q ^ ferr_d;
`endif

endmodule

// File: tb/tb_led_model.sv
// Two chained LED models driven with random frames and checked
// each cycle against a frame-level bit-queue model.
module tb_led_model;

  localparam int FREQ = 10_000_000;
  localparam int LUS  = 2;
  localparam int L    = FREQ / 1_000_000 * LUS;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sdi = 1'b0;
  logic        cki = 1'b0;
  logic        sdo0, cko0, sdo1, cko1;
  logic [23:0] rgb0, rgb1;
`ifdef LED_MODEL_FRAME_ERR_EN
  logic        ferr0, ferr1;
`endif

  always #5 clk = ~clk;

  led_model #(.FREQ(FREQ), .LATCH_US(LUS)) u0 (
    .clk(clk), .rst(rst), .SDI(sdi), .CKI(cki),
    .SDO(sdo0), .CKO(cko0), .rgb(rgb0)
`ifdef LED_MODEL_FRAME_ERR_EN
    , .frame_err(ferr0)
`endif
  );

  led_model #(.FREQ(FREQ), .LATCH_US(LUS)) u1 (
    .clk(clk), .rst(rst), .SDI(sdo0), .CKI(cko0),
    .SDO(sdo1), .CKO(cko1), .rgb(rgb1)
`ifdef LED_MODEL_FRAME_ERR_EN
    , .frame_err(ferr1)
`endif
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  bit          exp_valid = 1'b0;
  logic [23:0] mrgb [2];
  bit          mferr [2];
  bit          fb [$];
  int          rise0 = 0, rise1 = 0;
  int          base0 = 0, base1 = 0;
  logic        pc0 = 1'b0, pc1 = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 20)
        $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One clock: sample and compare on the falling edge, drive after rising.
  task automatic cyc();
    @(negedge clk);
    if (cko0 && !pc0) rise0++;
    if (cko1 && !pc1) rise1++;
    pc0 = cko0;
    pc1 = cko1;
    if (!rst) begin
      chk("rst_sdo0", {31'd0, sdo0}, 0);
      chk("rst_cko0", {31'd0, cko0}, 0);
      chk("rst_sdo1", {31'd0, sdo1}, 0);
      chk("rst_cko1", {31'd0, cko1}, 0);
    end
    if (exp_valid) begin
      chk("rgb0", {8'd0, rgb0}, {8'd0, mrgb[0]});
      chk("rgb1", {8'd0, rgb1}, {8'd0, mrgb[1]});
`ifdef LED_MODEL_FRAME_ERR_EN
      chk("ferr0", {31'd0, ferr0}, {31'd0, mferr[0]});
      chk("ferr1", {31'd0, ferr1}, {31'd0, mferr[1]});
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b, input int lo, input int hi);
    sdi = b;
    cki = 1'b0;
    repeat (lo) cyc();
    cki = 1'b1;
    repeat (hi) cyc();
  endtask

  task automatic send_frame(input logic [63:0] v, input int n,
                            input int gap_at);
    for (int i = 0; i < n; i++) begin
      int lo;
      lo = (i == gap_at) ? L - 1 : int'($urandom_range(3, 8));
      send_bit(v[n-1-i], lo, int'($urandom_range(3, 6)));
      fb.push_back(v[n-1-i]);
    end
  endtask

  // Hold CKI low past the latch time, then apply the frame to the model.
  task automatic latch();
    int n;
    int e0, e1;
    exp_valid = 1'b0;
    cki = 1'b0;
    sdi = 1'($urandom);
    repeat (L + 12) cyc();
    n = fb.size();
    for (int k = 0; k < 2; k++) begin
      int s;
      logic [23:0] v;
      s = 24 * k;
      v = '0;
      if (n >= s + 24) begin
        for (int j = 0; j < 24; j++) v = {v[22:0], fb[s+j]};
        mrgb[k] = v;
      end else if (n > s) begin
        mferr[k] = 1'b1;
      end
    end
    e0 = (n > 24) ? n - 24 : 0;
    e1 = (n > 48) ? n - 48 : 0;
    chk("cko0_pulses", rise0 - base0, e0);
    chk("cko1_pulses", rise1 - base1, e1);
    base0 = rise0;
    base1 = rise1;
    fb.delete();
    exp_valid = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cki = 1'b0;
    sdi = 1'b0;
    mrgb[0] = '0;
    mrgb[1] = '0;
    mferr[0] = 1'b0;
    mferr[1] = 1'b0;
    fb.delete();
    repeat (4) cyc();
    rst = 1'b1;
    base0 = rise0;
    base1 = rise1;
    repeat (2) cyc();
  endtask

  initial begin
    mrgb[0] = '0;
    mrgb[1] = '0;
    mferr[0] = 1'b0;
    mferr[1] = 1'b0;
    #1 rst = 1'b0;
    exp_valid = 1'b1;
    repeat (40) begin
      sdi = 1'($urandom);
      cki = 1'($urandom);
      cyc();
    end
    cki = 1'b0;
    sdi = 1'b0;
    cyc();
    rst = 1'b1;
    repeat (3) cyc();

    send_frame(64'h800000, 24, -1);
    latch();
    chk("pin_model_800000", {8'd0, mrgb[0]}, 32'h800000);
    chk("pin_rgb0_800000", {8'd0, rgb0}, 32'h800000);

    send_frame(64'hFFFFFF_555555, 48, -1);
    latch();
    chk("pin_rgb0_ffffff", {8'd0, rgb0}, 32'hFFFFFF);
    chk("pin_rgb1_555555", {8'd0, rgb1}, 32'h555555);

    send_frame(64'hABC, 12, -1);
    latch();
    chk("pin_rgb0_hold", {8'd0, rgb0}, 32'hFFFFFF);
    chk("pin_model_hold", {8'd0, mrgb[0]}, 32'hFFFFFF);
`ifdef LED_MODEL_FRAME_ERR_EN
    chk("pin_ferr0", {31'd0, ferr0}, 1);
`endif

    send_frame(64'h0000FF, 24, 12);
    latch();
    chk("pin_rgb0_gap", {8'd0, rgb0}, 32'h0000FF);

    send_frame(64'h3FF, 10, -1);
    do_reset();
    chk("pin_rgb0_rst", {8'd0, rgb0}, 32'h0);
    send_frame(64'h000001, 24, -1);
    latch();
    chk("pin_rgb0_000001", {8'd0, rgb0}, 32'h000001);
    chk("pin_rgb1_cleared", {8'd0, rgb1}, 32'h0);

    for (int f = 0; f < 25; f++) begin
      logic [63:0] v;
      int n, gap;
      v = {$urandom, $urandom};
      n = int'($urandom_range(0, 60));
      gap = -1;
      if (n > 1 && $urandom_range(0, 3) == 0)
        gap = int'($urandom_range(1, n - 1));
      if ($urandom_range(0, 7) == 0) begin
        send_frame(~v, int'($urandom_range(1, 40)), -1);
        do_reset();
      end
      send_frame(v, n, gap);
      latch();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
